// File: rtl/alu_md_seq.sv
// alu_md_seq: single-cycle ALU plus iterative MULTU/DIVU into HI/LO.
// Ports: clk, reset(async hi), start/funct/dataA/dataB in; result,
// result_valid, busy, bad_op out. Option macro: ALU_MD_SIGNED_EN.
module alu_md_seq #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             bad_op
);

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
`ifdef ALU_MD_SIGNED_EN
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_DIV   = 6'b011010;
`endif

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t               state_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opm_q;
  logic [WIDTH-1:0]     opa_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [WIDTH-1:0]     result_q;
  logic                 valid_q;
  logic                 bad_q;
  logic                 mul_q;
  logic                 nlo_q;
  logic                 nhi_q;

  logic                 accept;
  logic [WIDTH-1:0]     alu_r;
  logic                 op_alu;
  logic                 op_mul;
  logic                 op_div;
  logic                 op_sgn;
  logic                 sa;
  logic                 sb;
  logic [WIDTH-1:0]     amag;
  logic [WIDTH-1:0]     bmag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_rem;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   nxt;
  logic [WIDTH-1:0]     fin_hi;
  logic [WIDTH-1:0]     fin_lo;

  assign busy   = (state_q == MUL) || (state_q == DIV);
  assign accept = start && !busy;

  always_comb begin
    alu_r  = result_q;
    op_alu = 1'b0;
    op_mul = 1'b0;
    op_div = 1'b0;
    op_sgn = 1'b0;
    unique case (1'b1)
      funct == F_AND:   begin alu_r = dataA & dataB; op_alu = 1'b1; end
      funct == F_OR:    begin alu_r = dataA | dataB; op_alu = 1'b1; end
      funct == F_ADD:   begin alu_r = dataA + dataB; op_alu = 1'b1; end
      funct == F_SUB:   begin alu_r = dataA - dataB; op_alu = 1'b1; end
      funct == F_SLT: begin
        alu_r  = {{(WIDTH-1){1'b0}}, $signed(dataA) < $signed(dataB)};
        op_alu = 1'b1;
      end
      funct == F_SRL: begin
        alu_r  = dataB >> dataA[SHAMT_W-1:0];
        op_alu = 1'b1;
      end
      funct == F_MFHI:  begin alu_r = hi_q; op_alu = 1'b1; end
      funct == F_MFLO:  begin alu_r = lo_q; op_alu = 1'b1; end
      funct == F_MULTU: op_mul = 1'b1;
      funct == F_DIVU:  op_div = 1'b1;
`ifdef ALU_MD_SIGNED_EN
      funct == F_MULT:  begin op_mul = 1'b1; op_sgn = 1'b1; end
      funct == F_DIV:   begin op_div = 1'b1; op_sgn = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Signed ops feed magnitudes to the unsigned engine.
  assign sa   = op_sgn && dataA[WIDTH-1];
  assign sb   = op_sgn && dataB[WIDTH-1];
  assign amag = sa ? ('0 - dataA) : dataA;
  assign bmag = sb ? ('0 - dataB) : dataB;

  // Shift-add: multiplier sits in acc low half, product grows from top.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, opm_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide: {remainder, dividend/quotient} shifts left.
  assign div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_rem - {1'b0, opm_q};
  assign div_ge   = !div_diff[WIDTH];
  assign div_next = {div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0],
                     acc_q[WIDTH-2:0], div_ge};

  always_comb begin
    nxt = (state_q == MUL) ? mul_next : div_next;
    {fin_hi, fin_lo} = nxt;
    if (mul_q) begin
      if (nlo_q) {fin_hi, fin_lo} = '0 - nxt;
    end else begin
      if (nlo_q) fin_lo = '0 - nxt[WIDTH-1:0];
      if (nhi_q) fin_hi = '0 - nxt[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opm_q    <= '0;
      opa_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      bad_q    <= 1'b0;
      mul_q    <= 1'b0;
      nlo_q    <= 1'b0;
      nhi_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      bad_q   <= 1'b0;
      unique case (state_q)
        MUL, DIV: begin
          if (state_q == DIV && opm_q == '0) begin
            hi_q    <= opa_q;
            lo_q    <= '1;
            valid_q <= 1'b1;
            state_q <= FIN;
          end else begin
            acc_q <= nxt;
            cnt_q <= cnt_q + 1'b1;
            // Last iteration lands straight in HI/LO on entry to FIN.
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              hi_q    <= fin_hi;
              lo_q    <= fin_lo;
              valid_q <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        FIN:     state_q <= IDLE;
        default: ;
      endcase
      if (accept) begin
        if (op_alu) begin
          result_q <= alu_r;
          valid_q  <= 1'b1;
        end else if (op_mul) begin
          state_q <= MUL;
          acc_q   <= {{WIDTH{1'b0}}, bmag};
          opm_q   <= amag;
          mul_q   <= 1'b1;
          nlo_q   <= sa ^ sb;
          nhi_q   <= sa ^ sb;
        end else if (op_div) begin
          state_q <= DIV;
          acc_q   <= {{WIDTH{1'b0}}, amag};
          opm_q   <= bmag;
          opa_q   <= dataA;
          mul_q   <= 1'b0;
          nlo_q   <= sa ^ sb;
          nhi_q   <= sa;
        end else begin
          bad_q <= 1'b1;
        end
      end
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign bad_op       = bad_q;

endmodule

// File: tb/tb_alu_md_seq.sv
// tb_alu_md_seq: directed + random checks of alu_md_seq
// against a plain-arithmetic reference model (WIDTH=32 and 8).
module tb_alu_md_seq;
  localparam int W = 32;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_DIV   = 6'b011010;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [5:0]   funct;
  logic [W-1:0] dataA, dataB, result;
  logic         result_valid, busy, bad_op;

  logic         start8;
  logic [5:0]   funct8;
  logic [7:0]   a8, b8, result8;
  logic         v8, busy8, bad8;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] hi_m = '0, lo_m = '0, res_m = '0;

  always #5 clk = ~clk;

  alu_md_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .dataA(dataA), .dataB(dataB), .result(result),
    .result_valid(result_valid), .busy(busy), .bad_op(bad_op)
  );

  alu_md_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .funct(funct8),
    .dataA(a8), .dataB(b8), .result(result8),
    .result_valid(v8), .busy(busy8), .bad_op(bad8)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] alu_ref(input logic [5:0] f,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (f)
      F_AND:  return a & b;
      F_OR:   return a | b;
      F_ADD:  return a + b;
      F_SUB:  return a - b;
      F_SLT:  return ($signed(a) < $signed(b)) ? 1 : 0;
      F_SRL:  return b >> (a % W);
      F_MFHI: return hi_m;
      F_MFLO: return lo_m;
      default: return res_m;
    endcase
  endfunction

  task automatic run_alu(input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input string tag);
    logic [W-1:0] exp;
    exp = alu_ref(f, a, b);
    @(negedge clk);
    funct = f; dataA = a; dataB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " valid"}, result_valid, 1);
    chk({tag, " result"}, result, exp);
    res_m = exp;
  endtask

  task automatic run_bad(input logic [5:0] f, input string tag);
    @(negedge clk);
    funct = f; dataA = $urandom; dataB = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " bad_op"}, bad_op, 1);
    chk({tag, " no valid"}, result_valid, 0);
    chk({tag, " result held"}, result, res_m);
    @(negedge clk);
    chk({tag, " bad_op drop"}, bad_op, 0);
  endtask

  // inject: pulse an ADD and scramble operands while busy.
  task automatic run_md(input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit inject,
                        input string tag);
    logic [63:0] p;
    longint q, r;
    logic [W-1:0] ehi, elo;
    int lat, n, nb;
    lat = W + 1;
    case (f)
      F_MULTU: begin p = 64'(a) * 64'(b); {ehi, elo} = p; end
      F_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {ehi, elo} = p;
      end
      default: begin
        if (b == 0) begin
          ehi = a; elo = '1; lat = 2;
        end else if (f == F_DIV) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          elo = q[W-1:0]; ehi = r[W-1:0];
        end else begin
          elo = a / b; ehi = a % b;
        end
      end
    endcase
    @(negedge clk);
    funct = f; dataA = a; dataB = b; start = 1'b1;
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (busy) nb++;
      if (inject && n == 5) begin
        funct = F_ADD; dataA = $urandom; dataB = $urandom; start = 1'b1;
      end
      if (inject && n == 8) start = 1'b0;
    end while (!result_valid && n < 200);
    chk({tag, " latency"}, n, lat);
    chk({tag, " busy cycles"}, nb, lat - 1);
    chk({tag, " busy low at done"}, busy, 0);
    chk({tag, " result held"}, result, res_m);
    hi_m = ehi; lo_m = elo;
    run_alu(F_MFHI, '0, '0, {tag, " MFHI"});
    run_alu(F_MFLO, '0, '0, {tag, " MFLO"});
  endtask

  initial begin
    logic [5:0] fl [8];
    int n;
    bit seen;
    fl = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MFHI, F_MFLO};
    reset = 1'b1; start = 1'b0; funct = '0; dataA = '0; dataB = '0;
    start8 = 1'b0; funct8 = '0; a8 = '0; b8 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset result", result, 0);
    chk("reset valid", result_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset bad_op", bad_op, 0);
    reset = 1'b0;

    run_alu(F_ADD, 32'hFFFFFFFF, 32'h2, "ADD wrap");
    @(negedge clk);
    chk("valid one pulse", result_valid, 0);
    run_alu(F_SLT, 32'hFFFFFFFE, 32'h1, "SLT signed");
    run_alu(F_SRL, 32'h4, 32'h80000000, "SRL");
    run_md(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "MULTU max");
    run_md(F_DIVU, 100, 7, 0, "DIVU 100/7");
    run_md(F_DIVU, 5, 0, 0, "DIVU by zero");

    for (int i = 0; i < 24; i++)
      run_alu(fl[$urandom_range(7)], $urandom, $urandom, "rand alu");
    for (int i = 0; i < 6; i++)
      run_md((i % 2) ? F_DIVU : F_MULTU, $urandom,
             (i == 5) ? 32'($urandom_range(20)) : 32'($urandom),
             0, "rand md");

    run_md(F_MULTU, $urandom, $urandom, 1, "MULTU start-while-busy");
    run_bad(6'b111111, "bad 111111");
`ifdef ALU_MD_SIGNED_EN
    run_md(F_MULT, $urandom, $urandom, 0, "MULT rand");
    run_md(F_DIV, -32'sd100, 7, 0, "DIV -100/7");
    run_md(F_DIV, 32'h80000000, 32'hFFFFFFFF, 0, "DIV min/-1");
    run_md(F_DIV, 32'hFFFFFFF0, 0, 0, "DIV by zero");
`else
    run_bad(F_MULT, "bad MULT");
    run_bad(F_DIV, "bad DIV");
`endif

    // Abandon a multiply at iteration 10 with reset.
    @(negedge clk);
    funct = F_MULTU; dataA = $urandom; dataB = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset result", result, 0);
    chk("mid reset valid", result_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    hi_m = '0; lo_m = '0; res_m = '0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (result_valid || busy) seen = 1;
    end
    chk("no completion after reset", seen, 0);
    run_alu(F_MFHI, '0, '0, "HI cleared");
    run_alu(F_MFLO, '0, '0, "LO cleared");

    // WIDTH=8 instance.
    @(negedge clk);
    funct8 = F_MULTU; a8 = 8'hFF; b8 = 8'h02; start8 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      n++;
    end while (!v8 && n < 50);
    chk("W8 MULTU latency", n, 9);
    @(negedge clk);
    funct8 = F_MFHI; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("W8 MFHI", result8, 8'h01);
    @(negedge clk);
    funct8 = F_MFLO; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("W8 MFLO", result8, 8'hFE);
    @(negedge clk);
    funct8 = 6'b111111; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("W8 bad_op", bad8, 1);
    chk("W8 bad no valid", v8, 0);
    chk("W8 bad result held", result8, 8'hFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_md_seq.md
Name: alu_md_seq

Overview:
- Parametrised successor of the single-issue ALU/multiplier datapath.
- One unit that executes logic, arithmetic, compare and shift ops in a single cycle, and unsigned multiply and divide iteratively into internal HI/LO registers.
- Has a start/busy/valid handshake, so the CPU control stalls on it instead of relying on fixed timing.
- Sits between the decode stage (supplies funct) and the writeback mux (consumes result).

Parameters:
- WIDTH, 32, operand/result width; must be >= 4 and a power of two.
- SHAMT_W, $clog2(WIDTH), shift-amount width. Derived; never overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  issue strobe; an op is accepted when start=1 and busy=0.
- funct  in  6  op select, sampled on accept: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, SRL 000010, MULTU 011001, DIVU 011011, MFHI 010000, MFLO 010010.
- dataA  in  WIDTH  operand A, sampled on accept.
- dataB  in  WIDTH  operand B, sampled on accept.
- result  out  WIDTH  registered result; holds its value until the next result_valid.
- result_valid  out  1  one-cycle pulse when result is updated or a MULTU/DIVU completes.
- busy  out  1  high while a MULTU/DIVU is iterating.
- bad_op  out  1  one-cycle pulse when an undefined funct is accepted.

Behaviour:
- Reset (asynchronous): result=0, result_valid=0, busy=0, bad_op=0, HI=0, LO=0, FSM=IDLE, iteration counter=0.
- FSM states: IDLE, MUL, DIV, FIN.
- Single-cycle ops accepted in IDLE (AND, OR, ADD, SUB, SLT, SRL, MFHI, MFLO): result is written on the accept edge; result_valid is high in the following cycle. Latency is 1.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- SLT is a signed compare: result = {WIDTH-1 zeros, (A<B)}.
- SRL: result = dataB >> dataA[SHAMT_W-1:0], logical shift, zero fill.
- MFHI/MFLO: result = HI/LO.
- MULTU: IDLE->MUL, busy=1 from the next cycle.
  - Radix-2 shift-add over exactly WIDTH cycles using a 2*WIDTH accumulator.
  - Then MUL->FIN for 1 cycle: {HI,LO}=A*B, busy drops, result_valid pulses, result unchanged. FIN->IDLE.
  - Total: WIDTH+1 cycles from accept to result_valid.
- DIVU: IDLE->DIV, restoring division over WIDTH cycles, then FIN: LO=quotient, HI=remainder. Same timing as MULTU.
- Divide by zero: no iteration. DIV->FIN after 1 cycle with LO = all ones and HI = dividend (A). result_valid pulses at FIN.
- start while busy=1: ignored. No state change, no pulse. Control must hold start until busy=0.
- start in FIN: accepted. busy is already 0 in FIN.
- HI/LO change only in FIN or on reset.
- MFHI/MFLO accepted in the cycle after FIN return the new values.
- Undefined funct: result unchanged, bad_op pulses the next cycle, result_valid stays 0.
- Reset asserted mid-iteration: the operation is abandoned, HI/LO are cleared, and no result_valid is produced.
- Operands are captured on accept; dataA/dataB changes during busy have no effect.

Optional Feature:
- Macro: ALU_MD_SIGNED_EN.
- Defined: adds MULT (011000) and DIV (011010).
  - Operands are converted to magnitudes, run through the same unsigned engine, and the sign is corrected in FIN.
  - Latency is unchanged.
  - Remainder takes the sign of the dividend; quotient truncates toward zero.
  - Signed divide by zero behaves as DIVU by zero.
  - Most-negative / -1: LO = most-negative value, HI = 0.
- Not defined: 011000 and 011010 are undefined functs and raise bad_op.

Test Plan:
- Reset, then ADD A=0xFFFFFFFF B=0x00000002 -> result=0x00000001, result_valid 1 cycle after accept.
- SLT A=0xFFFFFFFE B=0x00000001 -> result=1. SRL A=4 B=0x80000000 -> result=0x08000000.
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy 32 cycles, result_valid on cycle 33; then MFHI=0xFFFFFFFE, MFLO=0x00000001.
- DIVU A=100 B=7 -> LO=14, HI=2. DIVU A=5 B=0 -> result_valid 2 cycles after accept, LO=0xFFFFFFFF, HI=5.
- start with ADD while busy (mid-MULTU) -> ignored, no result_valid until FIN. Reset at iteration 10 -> busy=0 and HI=LO=0 immediately.
- WIDTH=8 build: MULTU 0xFF*0x02 -> HI=0x01, LO=0xFE after 9 cycles. funct=111111 -> bad_op pulse, result unchanged.
